reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the Tomasulo core.
- Accepts issued instructions from the decoder/dispatcher and captures results from the CDB.
- Retires the head entry into the register file on its `updated_index`/`updated_value` writer port, and forwards ready operands to reservation stations.
- On a branch mispredict at retirement, raises `jump_wrong` with the correct target and flushes all speculative state.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
ROB_IDX_W, 4, log2(ROB_SIZE), width of ROB tags
DATA_W, 32, data/address width
REG_IDX_W, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rdy  in  1  global enable; when low all state frozen
issue_valid  in  1  dispatcher presents an instruction this cycle
issue_rd  in  REG_IDX_W  destination register (0 = no write)
issue_is_branch  in  1  entry is a conditional branch
issue_pred_taken  in  1  predicted direction
rob_full  out  1  combinational, count == ROB_SIZE
issue_tag  out  ROB_IDX_W  combinational, tag given to an accepted issue (= tail)
cdb_valid  in  1  result broadcast valid
cdb_tag  in  ROB_IDX_W  producing entry
cdb_value  in  DATA_W  result value
cdb_taken  in  1  actual branch direction
cdb_target  in  DATA_W  correct next PC for the branch
query_tag1  in  ROB_IDX_W  RS operand 1 lookup
query_ready1  out  1  operand 1 available
query_value1  out  DATA_W  operand 1 value
query_tag2  in  ROB_IDX_W  RS operand 2 lookup
query_ready2  out  1  operand 2 available
query_value2  out  DATA_W  operand 2 value
commit_valid  out  1  registered pulse, write regfile
updated_index  out  REG_IDX_W  register being written
updated_value  out  DATA_W  value written
commit_tag  out  ROB_IDX_W  tag retired (regfile clears rename if matching)
jump_wrong  out  1  registered pulse, mispredict flush
jump_target  out  DATA_W  correct PC, valid with jump_wrong

Behaviour:
- Reset (async, rst=1):
  - head=tail=count=0; all busy/ready bits 0.
  - commit_valid=0, updated_index=0, updated_value=0, commit_tag=0, jump_wrong=0, jump_target=0.
  - Reset mid-operation discards all entries immediately.
- rdy=0: no state change. Registered pulses (commit_valid, jump_wrong) drive 0 on the next edge.
- Issue:
  - Accepted when issue_valid && !rob_full && rdy.
  - entry[tail] gets busy=1, ready=0, rd, is_branch, pred_taken.
  - tail advances modulo ROB_SIZE; count+1.
  - Issue while full is ignored; the dispatcher must hold.
- CDB:
  - If cdb_valid and entry[cdb_tag].busy: sets ready=1 and stores value, taken and target.
  - CDB to a non-busy entry is ignored.
- Retire:
  - Each cycle, if entry[head] is busy && ready (registered state only), retire it: clear busy, advance head, count-1.
  - Next cycle commit_valid=1 iff rd!=0; updated_index=rd, updated_value=value, commit_tag=head.
  - At most one retire per cycle.
  - A CDB write to the head entry retires no earlier than the following cycle.
- Mispredict:
  - Retiring a branch whose taken != pred_taken sets jump_wrong=1 and jump_target=stored target on the next cycle.
  - Same edge as the retire: all busy cleared, head=tail=count=0.
  - An issue in that same cycle is dropped.
  - rd write of the branch entry still occurs.
- Simultaneous issue + retire: count unchanged, both take effect. Full with simultaneous retire: issue still refused (rob_full is combinational on the current count).
- Wrap-around: head and tail wrap from ROB_SIZE-1 to 0. Full versus empty is distinguished by count, never by pointer equality.
- Query (combinational):
  - If cdb_valid && cdb_tag==query_tag: ready=1, value=cdb_value (bypass).
  - Else ready = busy && ready of the entry; value = stored value.
  - Value is 0 when not ready.
- Pulses are one cycle wide. Outputs hold their last values otherwise, except commit_valid/jump_wrong, which return to 0.

Test Plan:
- Reset, issue 3 entries rd=1,2,3; CDB tags 2,0,1 with values 0x22,0x11,0x33 → commits in order rd1=0x11, rd2=0x33, rd3=0x22 on consecutive cycles starting one cycle after tag1 ready; commit_tag 0,1,2.
- Issue 16 entries → rob_full=1, 17th issue ignored, issue_tag stays 0. Retire one → rob_full drops next cycle, next issue gets tag 0 (wrap).
- Branch pred_taken=0 at tag 1, CDB taken=1 target=0x1000, younger entries 2..4 ready → jump_wrong pulse with target 0x1000; entries 2..4 never commit; count=0; next issue_tag=0.
- query_tag1=5 while cdb_valid tag 5 value 0xABCD → query_ready1=1, value 0xABCD same cycle. Query of an unready busy tag → ready=0, value 0.
- rdy held low 4 cycles with the head entry ready → no commit, pointers frozen; commit occurs one cycle after rdy returns high.
- Entry with rd=0 and ready → retires (count decrements) with commit_valid=0. Assert rst mid-stream → all outputs 0 immediately, count=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order retirement buffer for the Tomasulo core
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_is_branch,
  input  logic                 issue_pred_taken,
  output logic                 rob_full,
  output logic [ROB_IDX_W-1:0] issue_tag,
  input  logic                 cdb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_tag,
  input  logic [DATA_W-1:0]    cdb_value,
  input  logic                 cdb_taken,
  input  logic [DATA_W-1:0]    cdb_target,
  input  logic [ROB_IDX_W-1:0] query_tag1,
  output logic                 query_ready1,
  output logic [DATA_W-1:0]    query_value1,
  input  logic [ROB_IDX_W-1:0] query_tag2,
  output logic                 query_ready2,
  output logic [DATA_W-1:0]    query_value2,
  output logic                 commit_valid,
  output logic [REG_IDX_W-1:0] updated_index,
  output logic [DATA_W-1:0]    updated_value,
  output logic [ROB_IDX_W-1:0] commit_tag,
  output logic                 jump_wrong,
  output logic [DATA_W-1:0]    jump_target
);

  localparam logic [ROB_IDX_W:0] FULL_COUNT = (ROB_IDX_W+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  ready;
  logic [ROB_SIZE-1:0]  br_mem;
  logic [ROB_SIZE-1:0]  pred_mem;
  logic [ROB_SIZE-1:0]  taken_mem;
  logic [REG_IDX_W-1:0] rd_mem     [ROB_SIZE];
  logic [DATA_W-1:0]    value_mem  [ROB_SIZE];
  logic [DATA_W-1:0]    target_mem [ROB_SIZE];

  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic [ROB_IDX_W:0]   count;

  logic issue_fire;
  logic retire_fire;
  logic mispredict;
  logic cdb_hit;

  assign rob_full    = (count == FULL_COUNT);
  assign issue_tag   = tail;
  assign issue_fire  = rdy && issue_valid && !rob_full;
  // Retirement looks only at registered ready, so a same-cycle CDB write waits one cycle.
  assign retire_fire = rdy && busy[head] && ready[head];
  assign mispredict  = retire_fire && br_mem[head] && (taken_mem[head] != pred_mem[head]);
  assign cdb_hit     = cdb_valid && busy[cdb_tag];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      ready         <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_valid  <= 1'b0;
      updated_index <= '0;
      updated_value <= '0;
      commit_tag    <= '0;
      jump_wrong    <= 1'b0;
      jump_target   <= '0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      jump_wrong   <= 1'b0;
    end else begin
      commit_valid <= retire_fire && (rd_mem[head] != '0);
      jump_wrong   <= mispredict;
      if (retire_fire) begin
        updated_index <= rd_mem[head];
        updated_value <= value_mem[head];
        commit_tag    <= head;
      end
      if (mispredict) begin
        // Everything younger than the branch is speculative: drop it, including any issue this cycle.
        jump_target <= target_mem[head];
        busy        <= '0;
        ready       <= '0;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (cdb_hit) begin
          ready[cdb_tag] <= 1'b1;
        end
        if (retire_fire) begin
          busy[head] <= 1'b0;
          head       <= head + ROB_IDX_W'(1);
        end
        if (issue_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + ROB_IDX_W'(1);
        end
        count <= count + (ROB_IDX_W+1)'(issue_fire) - (ROB_IDX_W+1)'(retire_fire);
      end
    end
  end

  // Payload storage needs no reset; busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (issue_fire) begin
        rd_mem[tail]   <= issue_rd;
        br_mem[tail]   <= issue_is_branch;
        pred_mem[tail] <= issue_pred_taken;
      end
      if (cdb_hit) begin
        value_mem[cdb_tag]  <= cdb_value;
        taken_mem[cdb_tag]  <= cdb_taken;
        target_mem[cdb_tag] <= cdb_target;
      end
    end
  end

  function automatic logic [DATA_W:0] lookup(input logic [ROB_IDX_W-1:0] tag);
    if (cdb_valid && cdb_tag == tag) begin
      return {1'b1, cdb_value};
    end else if (busy[tag] && ready[tag]) begin
      return {1'b1, value_mem[tag]};
    end else begin
      return '0;
    end
  endfunction

  assign {query_ready1, query_value1} = lookup(query_tag1);
  assign {query_ready2, query_value2} = lookup(query_tag2);

endmodule
